// File: rtl/rxstatus_monitor_pkg.sv
// Shared definitions for the RXSTATUS monitor: PIPE status codes, EVENT bit
// positions, link-health encodings and the code-to-strobe decoder.
package rxstatus_monitor_pkg;

  // PIPE RXSTATUS[2:0] codes
  localparam logic [2:0] ST_OK       = 3'b000;
  localparam logic [2:0] ST_SKP_ADD  = 3'b001;
  localparam logic [2:0] ST_SKP_REM  = 3'b010;
  localparam logic [2:0] ST_RXDET    = 3'b011;
  localparam logic [2:0] ST_DEC_ERR  = 3'b100;
  localparam logic [2:0] ST_BUFF_OVF = 3'b101;
  localparam logic [2:0] ST_BUFF_UNF = 3'b110;
  localparam logic [2:0] ST_DISP_ERR = 3'b111;

  // EVENT bit indices, MSB first in the same order as the encoder inputs
  localparam int EV_W           = 7;
  localparam int EV_SKP_ADDED   = 6;
  localparam int EV_SKP_REMOVED = 5;
  localparam int EV_RXDET       = 4;
  localparam int EV_DECODE_ERR  = 3;
  localparam int EV_BUFF_OVF    = 2;
  localparam int EV_BUFF_UNF    = 1;
  localparam int EV_DISP_ERR    = 0;

  // Link-health states as presented on LINK_STATE
  typedef enum logic [1:0] {
    LS_OK       = 2'b00,
    LS_DEGRADED = 2'b01,
    LS_FAULT    = 2'b10
  } link_state_e;

  // One-hot strobe for a status code; idle or ST_OK gives no strobe
  function automatic logic [EV_W-1:0] decode_event(input logic valid, input logic [2:0] code);
    logic [EV_W-1:0] ev;
    ev = '0;
    if (valid) begin
      case (code)
        ST_SKP_ADD:  ev[EV_SKP_ADDED]   = 1'b1;
        ST_SKP_REM:  ev[EV_SKP_REMOVED] = 1'b1;
        ST_RXDET:    ev[EV_RXDET]       = 1'b1;
        ST_DEC_ERR:  ev[EV_DECODE_ERR]  = 1'b1;
        ST_BUFF_OVF: ev[EV_BUFF_OVF]    = 1'b1;
        ST_BUFF_UNF: ev[EV_BUFF_UNF]    = 1'b1;
        ST_DISP_ERR: ev[EV_DISP_ERR]    = 1'b1;
        default:     ev = '0;
      endcase
    end
    return ev;
  endfunction

  // Codes 100..111 are errors; everything else is informational
  function automatic logic is_error(input logic valid, input logic [2:0] code);
    return valid & code[2];
  endfunction

endpackage

// File: rtl/rxstatus_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  // Count up on i_inc, stop at the maximum value, clear wins over increment
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!i_rst_n)
      r_count <= '0;
    else if (i_clr)
      r_count <= '0;
    else if (i_inc && (r_count != {CNT_W{1'b1}}))
      r_count <= r_count + CNT_W'(1);
  end

  assign o_count = r_count;

endmodule

// File: rtl/rxstatus_monitor.sv
// RXSTATUS monitor: captures the PHY status code, decodes it into registered
// strobes, sticky flags and saturating counters, and tracks link health with
// a windowed error FSM that raises a level interrupt on FAULT.
// All inputs pass through one capture register first; decode, counters, FSM
// and IRQ all work on the captured copy, so a CLR or IRQ_ACK presented in the
// same cycle as a code acts on the same update as that code.
module rxstatus_monitor
  import rxstatus_monitor_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int WIN_LEN      = 256,
  parameter int FAULT_THRESH = 4
) (
  input  logic             CLK,
  input  logic             RESET_L,
  input  logic             RXSTATUS_VALID,
  input  logic [2:0]       RXSTATUS,
  input  logic             CLR,
  input  logic             IRQ_ACK,
  output logic [EV_W-1:0]  EVENT,
  output logic [EV_W-1:0]  STICKY,
  output logic [CNT_W-1:0] SKP_CNT,
  output logic [CNT_W-1:0] DEC_ERR_CNT,
  output logic [CNT_W-1:0] BUFF_ERR_CNT,
  output logic [CNT_W-1:0] DISP_ERR_CNT,
  output logic [1:0]       LINK_STATE,
  output logic             IRQ
);

  localparam int WIN_W = (WIN_LEN > 2) ? $clog2(WIN_LEN) : 1;
  localparam int ERR_W = $clog2(FAULT_THRESH + 1);

  logic             r_valid_q;
  logic [2:0]       r_code_q;
  logic             r_clr_q;
  logic             r_ack_q;
  logic [EV_W-1:0]  r_event;
  logic [EV_W-1:0]  r_sticky;
  logic             r_irq;
  link_state_e      r_state;
  logic [WIN_W-1:0] r_win_cnt;
  logic [ERR_W-1:0] r_win_errs;

  logic [EV_W-1:0]  w_event;
  logic             w_err;
  link_state_e      w_state_nxt;
  logic [WIN_W-1:0] w_win_cnt_nxt;
  logic [ERR_W-1:0] w_win_errs_nxt;
  logic [ERR_W-1:0] w_errs_inc;
  logic             w_enter_fault;

  assign w_event = decode_event(r_valid_q, r_code_q);
  assign w_err   = is_error(r_valid_q, r_code_q);

  // Input capture stage
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      r_valid_q <= 1'b0;
      r_code_q  <= ST_OK;
      r_clr_q   <= 1'b0;
      r_ack_q   <= 1'b0;
    end else begin
      r_valid_q <= RXSTATUS_VALID;
      r_code_q  <= RXSTATUS;
      r_clr_q   <= CLR;
      r_ack_q   <= IRQ_ACK;
    end
  end

  // Event strobe (unaffected by CLR) and sticky accumulation (cleared by CLR)
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      r_event  <= '0;
      r_sticky <= '0;
    end else begin
      r_event  <= w_event;
      r_sticky <= r_clr_q ? '0 : (r_sticky | w_event);
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_skp_cnt (
    .i_clk(CLK), .i_rst_n(RESET_L),
    .i_inc(w_event[EV_SKP_ADDED] | w_event[EV_SKP_REMOVED]),
    .i_clr(r_clr_q), .o_count(SKP_CNT)
  );

  sat_counter #(.CNT_W(CNT_W)) u_dec_err_cnt (
    .i_clk(CLK), .i_rst_n(RESET_L),
    .i_inc(w_event[EV_DECODE_ERR]),
    .i_clr(r_clr_q), .o_count(DEC_ERR_CNT)
  );

  sat_counter #(.CNT_W(CNT_W)) u_buff_err_cnt (
    .i_clk(CLK), .i_rst_n(RESET_L),
    .i_inc(w_event[EV_BUFF_OVF] | w_event[EV_BUFF_UNF]),
    .i_clr(r_clr_q), .o_count(BUFF_ERR_CNT)
  );

  sat_counter #(.CNT_W(CNT_W)) u_disp_err_cnt (
    .i_clk(CLK), .i_rst_n(RESET_L),
    .i_inc(w_event[EV_DISP_ERR]),
    .i_clr(r_clr_q), .o_count(DISP_ERR_CNT)
  );

  // Link-health state register together with its window counters
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      r_state    <= LS_OK;
      r_win_cnt  <= '0;
      r_win_errs <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_win_cnt  <= w_win_cnt_nxt;
      r_win_errs <= w_win_errs_nxt;
    end
  end

  // Next-state logic: open a window on an error, fault on a cluster, expire otherwise
  always_comb begin
    // NOTE: every combinational output gets a default up front so no path
    // through the case leaves it unassigned and infers a latch.
    w_state_nxt    = r_state;
    w_win_cnt_nxt  = r_win_cnt;
    w_win_errs_nxt = r_win_errs;
    w_errs_inc     = r_win_errs + ERR_W'(1);
    case (r_state)
      LS_OK: begin
        if (w_err) begin
          w_state_nxt    = (FAULT_THRESH == 1) ? LS_FAULT : LS_DEGRADED;
          w_win_cnt_nxt  = '0;
          w_win_errs_nxt = ERR_W'(1);
        end
      end
      LS_DEGRADED: begin
        if (w_err && (w_errs_inc >= ERR_W'(FAULT_THRESH))) begin
          w_state_nxt    = LS_FAULT;
          w_win_errs_nxt = w_errs_inc;
        end else if (r_win_cnt == WIN_W'(WIN_LEN - 1)) begin
          w_state_nxt    = LS_OK;
          w_win_cnt_nxt  = '0;
          w_win_errs_nxt = '0;
        end else begin
          w_win_cnt_nxt  = r_win_cnt + WIN_W'(1);
          w_win_errs_nxt = w_err ? w_errs_inc : r_win_errs;
        end
      end
      LS_FAULT: w_state_nxt = LS_FAULT;
      default:  w_state_nxt = LS_OK;
    endcase
    if (r_clr_q) begin
      w_state_nxt    = LS_OK;
      w_win_cnt_nxt  = '0;
      w_win_errs_nxt = '0;
    end
  end

  // FSM outputs: visible state and the fault-entry pulse that sets IRQ
  always_comb begin
    LINK_STATE    = r_state;
    w_enter_fault = (w_state_nxt == LS_FAULT) && (r_state != LS_FAULT);
  end

  // Interrupt: set on fault entry (beats a same-cycle ack), cleared by ack or CLR
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L)
      r_irq <= 1'b0;
    else if (r_clr_q)
      r_irq <= 1'b0;
    else if (w_enter_fault)
      r_irq <= 1'b1;
    else if (r_ack_q)
      r_irq <= 1'b0;
  end

  assign EVENT  = r_event;
  assign STICKY = r_sticky;
  assign IRQ    = r_irq;

endmodule
